// File: rtl/umi_axi_bridge.sv
// umi_axi_bridge: UMI request port to AXI master bridge, one transaction in flight.
// Writes use AW/W/B. Reads use AR/R and return a UMI response packet.
// Packet layout (PW bits, LSB first):
//   [31:0]       cmd (opcode in [7:0])
//   [32+:AW]     dstaddr
//   [32+AW+:AW]  srcaddr
//   [PW-1:32+2AW] data
// Write data is zero-extended to DW. Read data is truncated to the data field width.
// Ports:
//   clk, rst (synchronous, active-high)
//   umi_in_*     request stream in (valid/ready)
//   umi_out_*    response stream out (valid/ready)
//   axi_aw*, axi_w*, axi_b*, axi_ar*, axi_r*   AXI master channels
//   err_count    saturating error counter
// Optional feature: define UMI_AXI_WRITE_ACK_EN to send a UMI write-ack packet
// (cmd CMD_WACK, data 0) for every completed write.
module umi_axi_bridge #(
    parameter int         PW        = 256,
    parameter int         AW        = 64,
    parameter int         DW        = 256,
    parameter logic [7:0] CMD_WRITE = 8'h02,
    parameter logic [7:0] CMD_READ  = 8'h08,
    parameter logic [7:0] CMD_RESP  = 8'h09,
    parameter logic [7:0] CMD_WACK  = 8'h03
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PW-1:0]   umi_in_packet,
    input  logic            umi_in_valid,
    output logic            umi_in_ready,
    output logic [PW-1:0]   umi_out_packet,
    output logic            umi_out_valid,
    input  logic            umi_out_ready,
    output logic            axi_awvalid,
    input  logic            axi_awready,
    output logic [AW-1:0]   axi_awaddr,
    output logic            axi_wvalid,
    input  logic            axi_wready,
    output logic [DW-1:0]   axi_wdata,
    output logic [DW/8-1:0] axi_wstrb,
    input  logic            axi_bvalid,
    output logic            axi_bready,
    input  logic [1:0]      axi_bresp,
    output logic            axi_arvalid,
    input  logic            axi_arready,
    output logic [AW-1:0]   axi_araddr,
    input  logic            axi_rvalid,
    output logic            axi_rready,
    input  logic [DW-1:0]   axi_rdata,
    input  logic [1:0]      axi_rresp,
    output logic [7:0]      err_count
);

    localparam int CW = 32;
    localparam int FW = PW - CW - 2 * AW;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RRESP,
        RESP
    } state_t;

    function automatic logic [PW-1:0] umi_pack(
        input logic [7:0]    cmd,
        input logic [AW-1:0] dst,
        input logic [AW-1:0] src,
        input logic [FW-1:0] data
    );
        return {data, src, dst, {(CW - 8){1'b0}}, cmd};
    endfunction

    // umi_unpack: field extraction from the incoming request
    logic [7:0]    in_cmd;
    logic [AW-1:0] in_dst;
    logic [AW-1:0] in_src;
    logic [FW-1:0] in_data;

    assign in_cmd  = umi_in_packet[7:0];
    assign in_dst  = umi_in_packet[CW +: AW];
    assign in_src  = umi_in_packet[CW + AW +: AW];
    assign in_data = umi_in_packet[PW-1 -: FW];

    logic unused_ok;
    assign unused_ok = ^{umi_in_packet[CW-1:8], axi_rdata[DW-1:FW], CMD_WACK};

    state_t        state_q, state_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] src_q, src_d;
    logic [FW-1:0] data_q, data_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          arvalid_q, arvalid_d;
    logic [PW-1:0] out_packet_q, out_packet_d;
    logic [7:0]    err_q, err_d;
    logic          err_inc;

    assign umi_in_ready   = (state_q == IDLE) && !rst;
    assign umi_out_valid  = (state_q == RESP);
    assign umi_out_packet = out_packet_q;
    assign axi_bready     = (state_q == WRESP);
    assign axi_rready     = (state_q == RRESP);
    assign axi_awvalid    = awvalid_q;
    assign axi_wvalid     = wvalid_q;
    assign axi_arvalid    = arvalid_q;
    assign axi_awaddr     = dst_q;
    assign axi_araddr     = dst_q;
    assign axi_wdata      = {{(DW - FW){1'b0}}, data_q};
    assign axi_wstrb      = '1;
    assign err_count      = err_q;

    always_comb begin
        state_d      = state_q;
        dst_d        = dst_q;
        src_d        = src_q;
        data_d       = data_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        out_packet_d = out_packet_q;
        err_inc      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (umi_in_valid) begin
                    dst_d  = in_dst;
                    src_d  = in_src;
                    data_d = in_data;
                    if (in_cmd == CMD_WRITE) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else if (in_cmd == CMD_READ) begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W complete independently, in any order
                if (awvalid_q && axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && axi_wready) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WRESP;
            end
            WRESP: begin
                if (axi_bvalid) begin
                    err_inc = (axi_bresp != 2'b00);
`ifdef UMI_AXI_WRITE_ACK_EN
                    out_packet_d = umi_pack(CMD_WACK, src_q, dst_q, '0);
                    state_d      = RESP;
`else
                    state_d = IDLE;
`endif
                end
            end
            RD: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (axi_rvalid) begin
                    err_inc      = (axi_rresp != 2'b00);
                    out_packet_d = umi_pack(CMD_RESP, src_q, dst_q,
                                            axi_rdata[FW-1:0]);
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (umi_out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        err_d = err_q;
        if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dst_q        <= '0;
            src_q        <= '0;
            data_q       <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            out_packet_q <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            data_q       <= data_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            out_packet_q <= out_packet_d;
            err_q        <= err_d;
        end
    end

endmodule
